// File: rtl/as2650_bus_pkg.sv
// rtl/as2650_bus_pkg.sv - shared state type and constants for the multiplexed bus sequencer
package as2650_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    DATA    = 2'd3
  } seq_state_t;

  // Width of the data-phase wait-state down-counter (covers 0..7 extra cycles)
  localparam int WS_CNT_W = 3;

  // A memory cycle needs the high address byte unless the latched page is known and matches;
  // I/O cycles only ever drive the low byte (the port number).
  function automatic logic need_addr_hi(input logic io, input logic hi_valid,
                                        input logic [7:0] hi_last, input logic [7:0] page);
    return !io && (!hi_valid || (page != hi_last));
  endfunction

endpackage

// File: rtl/membus_le_gate.sv
// rtl/membus_le_gate.sv - clk-high gating of the address latch enables
module membus_le_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic hi_phase,
  input  logic lo_phase,
  output logic le_hi,
  output logic le_lo
);

  logic hi_seen;
  logic lo_seen;

  // Record at the falling edge that a phase has used its high half, so the late fall of the
  // phase flag after the next rising edge cannot leak a sliver of enable.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_seen <= 1'b0;
      lo_seen <= 1'b0;
    end else begin
      hi_seen <= hi_phase;
      lo_seen <= lo_phase;
    end
  end

  assign le_hi = hi_phase & ~hi_seen & clk;
  assign le_lo = lo_phase & ~lo_seen & clk;

endmodule

// File: rtl/membus_sequencer.sv
// rtl/membus_sequencer.sv - multiplexed address/data bus sequencer with high-byte page caching
module membus_sequencer
  import as2650_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic        req_io,
  input  logic        req_iod,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic [7:0]  bus_out,
  input  logic [7:0]  bus_in,
  output logic        bus_dir,
  output logic        le_hi,
  output logic        le_lo,
  output logic        oe_n,
  output logic        we_n,
  output logic        ioc,
  output logic        iod
);

  localparam logic [WS_CNT_W-1:0] WS_LOAD = WS_CNT_W'(WAIT_STATES);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [WS_CNT_W-1:0] cnt;
  logic [15:0]         addr_l;
  logic                we_l;
  logic                io_l;
  logic                iod_l;
  logic [7:0]          wdata_l;
  logic                hi_valid;
  logic [7:0]          hi_last;
  logic                last_data;
  logic                accept;

  assign last_data = (state == DATA) && (cnt == '0);
  assign req_ready = (state == IDLE) || last_data;
  assign accept    = req_valid && req_ready;

  // Phase sequencing; a request taken in the last data cycle starts its address phase at once
  always_comb begin
    state_nxt = state;
    case (state)
      ADDR_HI: state_nxt = ADDR_LO;
      ADDR_LO: state_nxt = DATA;
      default: begin
        if (req_ready) begin
          if (!accept)
            state_nxt = IDLE;
          else if (need_addr_hi(req_io, hi_valid, hi_last, req_addr[15:8]))
            state_nxt = ADDR_HI;
          else
            state_nxt = ADDR_LO;
        end
      end
    endcase
  end

  // State, wait-state counter, page cache and completion response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_valid   <= 1'b0;
      hi_last    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= last_data;
      if (last_data && !we_l)
        resp_rdata <= bus_in;
      if (state == ADDR_HI) begin
        hi_last  <= addr_l[15:8];
        hi_valid <= 1'b1;
      end
      if (state == ADDR_LO)
        cnt <= WS_LOAD;
      else if ((state == DATA) && (cnt != '0))
        cnt <= cnt - 1'b1;
    end
  end

  // Request capture so the requester may change its inputs right after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_l  <= '0;
      we_l    <= 1'b0;
      io_l    <= 1'b0;
      iod_l   <= 1'b0;
      wdata_l <= '0;
    end else if (accept) begin
      addr_l  <= req_addr;
      we_l    <= req_we;
      io_l    <= req_io;
      iod_l   <= req_iod;
      wdata_l <= req_wdata;
    end
  end

  // Pad and strobe decode from the current phase; pads float except when this side drives
  always_comb begin
    bus_out = '0;
    bus_dir = 1'b1;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    ioc     = 1'b0;
    iod     = 1'b0;
    case (state)
      ADDR_HI: begin
        bus_out = addr_l[15:8];
        bus_dir = 1'b0;
      end
      ADDR_LO: begin
        bus_out = addr_l[7:0];
        bus_dir = 1'b0;
      end
      DATA: begin
        ioc = io_l & ~iod_l;
        iod = io_l & iod_l;
        if (we_l) begin
          we_n    = 1'b0;
          bus_out = wdata_l;
          bus_dir = 1'b0;
        end else begin
          oe_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  membus_le_gate u_le_gate (
    .clk      (clk),
    .rst_n    (rst_n),
    .hi_phase (state == ADDR_HI),
    .lo_phase (state == ADDR_LO),
    .le_hi    (le_hi),
    .le_lo    (le_lo)
  );

endmodule

// File: tb/tb_membus_sequencer.sv
// tb/tb_membus_sequencer.sv - directed self-checking bench for membus_sequencer
module tb_membus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_io, req_iod;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, bus_in, bus_out, resp_rdata;
  logic        resp_valid, bus_dir, le_hi, le_lo, oe_n, we_n, ioc, iod;

  logic        req_valid_w, req_ready_w, req_we_w, req_io_w, req_iod_w;
  logic [15:0] req_addr_w;
  logic [7:0]  req_wdata_w, bus_in_w, bus_out_w, resp_rdata_w;
  logic        resp_valid_w, bus_dir_w, le_hi_w, le_lo_w, oe_n_w, we_n_w, ioc_w, iod_w;

  membus_sequencer #(.WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_io(req_io), .req_iod(req_iod),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bus_out(bus_out), .bus_in(bus_in), .bus_dir(bus_dir), .le_hi(le_hi), .le_lo(le_lo),
    .oe_n(oe_n), .we_n(we_n), .ioc(ioc), .iod(iod)
  );

  membus_sequencer #(.WAIT_STATES(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_ready(req_ready_w),
    .req_addr(req_addr_w), .req_we(req_we_w), .req_io(req_io_w), .req_iod(req_iod_w),
    .req_wdata(req_wdata_w), .resp_valid(resp_valid_w), .resp_rdata(resp_rdata_w),
    .bus_out(bus_out_w), .bus_in(bus_in_w), .bus_dir(bus_dir_w), .le_hi(le_hi_w), .le_lo(le_lo_w),
    .oe_n(oe_n_w), .we_n(we_n_w), .ioc(ioc_w), .iod(iod_w)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  int hi_cnt = 0, lo_cnt = 0, oe_cnt = 0, we_cnt = 0, iod_cnt = 0, ioc_cnt = 0, resp_cnt = 0;
  int overlap_cnt = 0, le_low_viol = 0, we_dir_viol = 0;
  logic [7:0] hi_byte[$];
  logic [7:0] last_lo = 8'h00, last_we_data = 8'h00;

  // Cycle counter used to time transfers between acceptances
  always @(posedge clk) cyc <= cyc + 1;

  // Bus activity monitor for the zero-wait-state instance, sampled in the clk-high half
  initial forever begin
    @(posedge clk); #1;
    if (le_hi) begin hi_cnt++; hi_byte.push_back(bus_out); end
    if (le_lo) begin lo_cnt++; last_lo = bus_out; end
    if (!oe_n) oe_cnt++;
    if (!we_n) begin we_cnt++; last_we_data = bus_out; if (bus_dir) we_dir_viol++; end
    if (iod) iod_cnt++;
    if (ioc) ioc_cnt++;
    if (resp_valid) resp_cnt++;
    if ((int'(le_hi) + int'(le_lo) + int'(!oe_n) + int'(!we_n)) > 1) overlap_cnt++;
  end

  // Latch enables must be low in the clk-low half
  initial forever begin
    @(negedge clk); #1;
    if (le_hi || le_lo || le_hi_w || le_lo_w) le_low_viol++;
  end

  task automatic send(input logic [15:0] a, input logic we, input logic io, input logic iodv,
                      input logic [7:0] wd, input logic [7:0] din);
    int waited;
    waited = 0;
    req_addr = a; req_we = we; req_io = io; req_iod = iodv; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL send_ready addr=%h req_ready=%b required 1", a, req_ready);
    end
    @(posedge clk);
    last_acc = cyc;
    #1;
    bus_in = din;
  endtask

  task automatic settle();
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_io = 1'b0; req_iod = 1'b0;
    req_wdata = '0; bus_in = '0;
    req_valid_w = 1'b0; req_addr_w = '0; req_we_w = 1'b0; req_io_w = 1'b0; req_iod_w = 1'b0;
    req_wdata_w = '0; bus_in_w = '0;
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (resp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got=%h exp=00", resp_rdata); end
    n_cmp++; if (bus_out !== 8'h00) begin n_bad++; $display("FAIL rst_bus_out got=%h exp=00", bus_out); end
    n_cmp++; if (bus_dir !== 1'b1) begin n_bad++; $display("FAIL rst_bus_dir got=%b exp=1", bus_dir); end
    n_cmp++; if ({le_hi, le_lo, oe_n, we_n, ioc, iod} !== 6'b001100) begin
      n_bad++; $display("FAIL rst_strobes got=%b exp=001100", {le_hi, le_lo, oe_n, we_n, ioc, iod});
    end
    n_cmp++; if ({bus_dir_w, oe_n_w, resp_valid_w} !== 3'b110) begin
      n_bad++; $display("FAIL rst_w_outputs got=%b exp=110", {bus_dir_w, oe_n_w, resp_valid_w});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq_reads();
    int b_hi, b_lo, b_oe, b_resp, prev, gap_bad;
    b_hi = hi_cnt; b_lo = lo_cnt; b_oe = oe_cnt; b_resp = resp_cnt; gap_bad = 0;
    send(16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A);
    prev = last_acc;
    for (int a = 1; a <= 16'h0101; a++) begin
      send(16'(a), 1'b0, 1'b0, 1'b0, 8'h00, 8'(a) ^ 8'h5A);
      if (a == 1 || a == 16'h0101) begin
        n_cmp++;
        if (last_acc - prev !== 3) begin
          n_bad++; $display("FAIL seq_page_gap before=%h got=%0d exp=3", 16'(a), last_acc - prev);
        end
      end else if (last_acc - prev != 2) begin
        gap_bad++;
      end
      prev = last_acc;
    end
    settle();
    n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL seq_gap_2 bad=%0d exp=0", gap_bad); end
    n_cmp++; if (hi_cnt - b_hi !== 2) begin n_bad++; $display("FAIL seq_hi_cnt got=%0d exp=2", hi_cnt - b_hi); end
    n_cmp++; if (hi_byte[b_hi] !== 8'h00) begin n_bad++; $display("FAIL seq_hi_first got=%h exp=00", hi_byte[b_hi]); end
    n_cmp++; if (hi_byte[b_hi+1] !== 8'h01) begin n_bad++; $display("FAIL seq_hi_second got=%h exp=01", hi_byte[b_hi+1]); end
    n_cmp++; if (lo_cnt - b_lo !== 258) begin n_bad++; $display("FAIL seq_lo_cnt got=%0d exp=258", lo_cnt - b_lo); end
    n_cmp++; if (oe_cnt - b_oe !== 258) begin n_bad++; $display("FAIL seq_oe_cnt got=%0d exp=258", oe_cnt - b_oe); end
    n_cmp++; if (resp_cnt - b_resp !== 258) begin n_bad++; $display("FAIL seq_resp_cnt got=%0d exp=258", resp_cnt - b_resp); end
    n_cmp++; if (resp_rdata !== 8'h5B) begin n_bad++; $display("FAIL seq_rdata got=%h exp=5B", resp_rdata); end
  endtask

  task automatic test_page_hit();
    int b_hi;
    b_hi = hi_cnt;
    send(16'h0310, 1'b0, 1'b0, 1'b0, 8'h00, 8'h62);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 1) begin n_bad++; $display("FAIL hit_first_hi got=%0d exp=1", hi_cnt - b_hi); end
    n_cmp++; if (hi_byte[$] !== 8'h03) begin n_bad++; $display("FAIL hit_hi_byte got=%h exp=03", hi_byte[$]); end
    n_cmp++; if (resp_rdata !== 8'h62) begin n_bad++; $display("FAIL hit_rdata got=%h exp=62", resp_rdata); end
    b_hi = hi_cnt;
    send(16'h0311, 1'b0, 1'b0, 1'b0, 8'h00, 8'h17);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 0) begin n_bad++; $display("FAIL hit_second_hi got=%0d exp=0", hi_cnt - b_hi); end
    n_cmp++; if (last_lo !== 8'h11) begin n_bad++; $display("FAIL hit_lo_byte got=%h exp=11", last_lo); end
    n_cmp++; if (resp_rdata !== 8'h17) begin n_bad++; $display("FAIL hit_rdata2 got=%h exp=17", resp_rdata); end
  endtask

  task automatic test_write();
    int b_hi, b_we, b_oe, b_resp;
    b_hi = hi_cnt; b_we = we_cnt; b_oe = oe_cnt; b_resp = resp_cnt;
    send(16'h62CB, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h00);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 1) begin n_bad++; $display("FAIL wr_hi_cnt got=%0d exp=1", hi_cnt - b_hi); end
    n_cmp++; if (hi_byte[$] !== 8'h62) begin n_bad++; $display("FAIL wr_hi_byte got=%h exp=62", hi_byte[$]); end
    n_cmp++; if (last_lo !== 8'hCB) begin n_bad++; $display("FAIL wr_lo_byte got=%h exp=CB", last_lo); end
    n_cmp++; if (we_cnt - b_we !== 1) begin n_bad++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cnt - b_we); end
    n_cmp++; if (last_we_data !== 8'hA5) begin n_bad++; $display("FAIL wr_data got=%h exp=A5", last_we_data); end
    n_cmp++; if (oe_cnt - b_oe !== 0) begin n_bad++; $display("FAIL wr_oe_cycles got=%0d exp=0", oe_cnt - b_oe); end
    n_cmp++; if (we_dir_viol !== 0) begin n_bad++; $display("FAIL wr_bus_dir viol=%0d exp=0", we_dir_viol); end
    n_cmp++; if (resp_cnt - b_resp !== 1) begin n_bad++; $display("FAIL wr_resp got=%0d exp=1", resp_cnt - b_resp); end
  endtask

  task automatic test_io();
    int b_hi, b_iod, b_ioc;
    b_hi = hi_cnt;
    send(16'h0120, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 1) begin n_bad++; $display("FAIL io_pre_read_hi got=%0d exp=1", hi_cnt - b_hi); end
    b_hi = hi_cnt; b_iod = iod_cnt; b_ioc = ioc_cnt;
    send(16'h0040, 1'b1, 1'b1, 1'b1, 8'h9C, 8'h00);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 0) begin n_bad++; $display("FAIL io_no_hi got=%0d exp=0", hi_cnt - b_hi); end
    n_cmp++; if (iod_cnt - b_iod !== 1) begin n_bad++; $display("FAIL io_iod got=%0d exp=1", iod_cnt - b_iod); end
    n_cmp++; if (ioc_cnt - b_ioc !== 0) begin n_bad++; $display("FAIL io_ioc_idle got=%0d exp=0", ioc_cnt - b_ioc); end
    n_cmp++; if (last_lo !== 8'h40) begin n_bad++; $display("FAIL io_port got=%h exp=40", last_lo); end
    b_iod = iod_cnt; b_ioc = ioc_cnt;
    send(16'h0007, 1'b0, 1'b1, 1'b0, 8'h00, 8'hE1);
    settle();
    n_cmp++; if (ioc_cnt - b_ioc !== 1) begin n_bad++; $display("FAIL io_ctrl_ioc got=%0d exp=1", ioc_cnt - b_ioc); end
    n_cmp++; if (iod_cnt - b_iod !== 0) begin n_bad++; $display("FAIL io_ctrl_iod got=%0d exp=0", iod_cnt - b_iod); end
    n_cmp++; if (resp_rdata !== 8'hE1) begin n_bad++; $display("FAIL io_ctrl_rdata got=%h exp=E1", resp_rdata); end
    b_hi = hi_cnt;
    send(16'h0155, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4D);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 0) begin n_bad++; $display("FAIL io_post_read_hi got=%0d exp=0", hi_cnt - b_hi); end
    n_cmp++; if (resp_rdata !== 8'h4D) begin n_bad++; $display("FAIL io_post_rdata got=%h exp=4D", resp_rdata); end
  endtask

  task automatic test_wait_states();
    int oe_n_cyc, first_oe, last_oe, resp_at, resp_n, hi_w, waited;
    oe_n_cyc = 0; first_oe = -1; last_oe = -1; resp_at = -1; resp_n = 0; hi_w = 0; waited = 0;
    req_addr_w = 16'h0A10; req_we_w = 1'b0; req_io_w = 1'b0; req_iod_w = 1'b0; req_valid_w = 1'b1;
    while (!req_ready_w && waited < 20) begin @(posedge clk); #1; waited++; end
    n_cmp++; if (req_ready_w !== 1'b1) begin n_bad++; $display("FAIL ws_ready got=%b exp=1", req_ready_w); end
    @(posedge clk); #1;
    req_valid_w = 1'b0; bus_in_w = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      if (le_hi_w) hi_w++;
      if (!oe_n_w) begin oe_n_cyc++; if (first_oe < 0) first_oe = i; last_oe = i; end
      if (resp_valid_w) begin resp_n++; resp_at = i; end
      @(posedge clk); #1;
    end
    n_cmp++; if (hi_w !== 1) begin n_bad++; $display("FAIL ws_hi got=%0d exp=1", hi_w); end
    n_cmp++; if (oe_n_cyc !== 3) begin n_bad++; $display("FAIL ws_oe_cycles got=%0d exp=3", oe_n_cyc); end
    n_cmp++; if (first_oe !== 2) begin n_bad++; $display("FAIL ws_oe_start got=%0d exp=2", first_oe); end
    n_cmp++; if (resp_n !== 1) begin n_bad++; $display("FAIL ws_resp_count got=%0d exp=1", resp_n); end
    n_cmp++; if (resp_at !== 5) begin n_bad++; $display("FAIL ws_resp_pos got=%0d exp=5", resp_at); end
    n_cmp++; if (resp_rdata_w !== 8'hC3) begin n_bad++; $display("FAIL ws_rdata got=%h exp=C3", resp_rdata_w); end
  endtask

  task automatic test_reset_mid();
    int b_resp, b_hi;
    b_resp = resp_cnt;
    send(16'h0157, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44);
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (oe_n !== 1'b0) begin n_bad++; $display("FAIL mid_in_data oe_n=%b exp=0", oe_n); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if ({oe_n, we_n, bus_dir, le_hi, le_lo} !== 5'b11100) begin
      n_bad++; $display("FAIL mid_strobes got=%b exp=11100", {oe_n, we_n, bus_dir, le_hi, le_lo});
    end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_resp_valid got=%b exp=0", resp_valid); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #3;
    n_cmp++; if (resp_cnt - b_resp !== 0) begin n_bad++; $display("FAIL mid_no_resp got=%0d exp=0", resp_cnt - b_resp); end
    b_hi = hi_cnt;
    send(16'h0158, 1'b0, 1'b0, 1'b0, 8'h00, 8'h29);
    settle();
    n_cmp++; if (hi_cnt - b_hi !== 1) begin n_bad++; $display("FAIL mid_post_hi got=%0d exp=1", hi_cnt - b_hi); end
    n_cmp++; if (hi_byte[$] !== 8'h01) begin n_bad++; $display("FAIL mid_post_hi_byte got=%h exp=01", hi_byte[$]); end
    n_cmp++; if (resp_rdata !== 8'h29) begin n_bad++; $display("FAIL mid_post_rdata got=%h exp=29", resp_rdata); end
  endtask

  task automatic test_exclusive();
    n_cmp++; if (overlap_cnt !== 0) begin n_bad++; $display("FAIL excl_overlap got=%0d exp=0", overlap_cnt); end
    n_cmp++; if (le_low_viol !== 0) begin n_bad++; $display("FAIL excl_le_low_half got=%0d exp=0", le_low_viol); end
  endtask

  initial begin
    test_reset();
    test_seq_reads();
    test_page_hit();
    test_write();
    test_io();
    test_wait_states();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
